// File: rtl/cat_out_logger.sv
// Change-capture logger for the cat controller output vector: every change of y_in
// while enabled is stored with a timestamp in a small FIFO drained via valid/ready.
module cat_out_logger #(
    parameter int WIDTH  = 22,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 8,
    parameter int DROP_W = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  y_in,
    input  logic              capture_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_word,
    output logic [TS_W-1:0]   out_ts,
    output logic [PW-1:0]     level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [WIDTH-1:0]      prev_y;
    logic [TS_W-1:0]       ts;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [WIDTH+TS_W-1:0] mem [DEPTH];

    logic evt;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        evt   = capture_en && (y_in != prev_y);
        empty = (wr_ptr == rd_ptr);
        // Same slot, opposite lap: the writer is exactly DEPTH entries ahead.
        full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        pop   = !empty && out_ready;
        push  = evt && (!full || pop);
        drop  = evt && full && !pop;
    end

    assign out_valid           = !empty;
    assign level               = wr_ptr - rd_ptr;
    assign {out_word, out_ts}  = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_y   <= '0;
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (capture_en) begin
                prev_y <= y_in;
                ts     <= ts + TS_W'(1);
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, so a reset only has to clear them.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr[AW-1:0]] <= {y_in, ts};
    end

endmodule

// File: tb/tb_cat_out_logger.sv
// Self-checking bench for cat_out_logger: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_cat_out_logger;

    localparam int WIDTH  = 22;
    localparam int DEPTH  = 4;
    localparam int TS_W   = 4;
    localparam int DROP_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [WIDTH-1:0]  y_in = '0;
    logic              capture_en = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [WIDTH-1:0]  out_word;
    logic [TS_W-1:0]   out_ts;
    logic [2:0]        level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    cat_out_logger #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .capture_en(capture_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_ts(out_ts), .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (act=running exp=finished)");
        $fatal(1, "watchdog");
    end

    // Reference model: a queue of {word, ts} plus the counters, updated once per edge.
    typedef struct {
        logic [WIDTH-1:0] w;
        logic [TS_W-1:0]  t;
    } ent_t;

    ent_t             mq[$];
    logic [WIDTH-1:0] m_prev = '0;
    int               m_ts = 0;
    bit               m_ovf = 0;
    int               m_drops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit evt;
        bit was_full;
        bit pop;
        if (rst) begin
            mq.delete();
            m_prev  = '0;
            m_ts    = 0;
            m_ovf   = 0;
            m_drops = 0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        pop      = out_ready && (mq.size() != 0);
        evt      = capture_en && (y_in != m_prev);
        if (pop) void'(mq.pop_front());
        if (evt) begin
            if (was_full && !pop) begin
                m_ovf = 1;
                if (m_drops < (2 ** DROP_W) - 1) m_drops++;
            end else begin
                mq.push_back('{w: y_in, t: TS_W'(m_ts)});
            end
        end
        if (capture_en) begin
            m_prev = y_in;
            m_ts   = (m_ts + 1) % (2 ** TS_W);
        end
    endtask

    task automatic model_check();
        check("m_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("m_level", 32'(level), 32'(mq.size()));
        check("m_overflow", 32'(overflow), 32'(m_ovf));
        check("m_drop_cnt", 32'(drop_cnt), 32'(m_drops));
        if (mq.size() != 0) begin
            check("m_word", 32'(out_word), 32'(mq[0].w));
            check("m_ts", 32'(out_ts), 32'(mq[0].t));
        end
    endtask

    // Applies one cycle of inputs, advances the model, samples outputs 1 ns after the edge.
    task automatic step(input logic r, input logic en, input logic rdy, input logic [WIDTH-1:0] y);
        rst        = r;
        capture_en = en;
        out_ready  = rdy;
        y_in       = y;
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    typedef struct {
        logic             rst;
        logic             en;
        logic             rdy;
        logic [WIDTH-1:0] y;
        logic             exp_valid;
        logic [2:0]       exp_level;
        logic [WIDTH-1:0] exp_word;
        logic [TS_W-1:0]  exp_ts;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic en, input logic rdy, input logic [WIDTH-1:0] y,
                                input logic v, input logic [2:0] l, input logic [WIDTH-1:0] w,
                                input logic [TS_W-1:0] t);
        vec_t x;
        x.rst = r; x.en = en; x.rdy = rdy; x.y = y;
        x.exp_valid = v; x.exp_level = l; x.exp_word = w; x.exp_ts = t;
        return x;
    endfunction

    vec_t tbl[9];

    initial begin
        logic [WIDTH-1:0] exp_heads[4];
        logic [TS_W-1:0]  exp_tss[4];
        bit               sup_seen;

        // First event after reset, then the suppressed y8/y9/y17 pulse.
        tbl[0] = mk(1'b1, 1'b0, 1'b0, 22'h000000, 1'b0, 3'd0, 22'h000000, 4'd0);
        tbl[1] = mk(1'b0, 1'b1, 1'b0, 22'h000482, 1'b1, 3'd1, 22'h000482, 4'd0);
        tbl[2] = mk(1'b0, 1'b1, 1'b0, 22'h000482, 1'b1, 3'd1, 22'h000482, 4'd0);
        tbl[3] = mk(1'b0, 1'b1, 1'b1, 22'h000482, 1'b0, 3'd0, 22'h000000, 4'd0);
        tbl[4] = mk(1'b1, 1'b0, 1'b0, 22'h000000, 1'b0, 3'd0, 22'h000000, 4'd0);
        tbl[5] = mk(1'b0, 1'b1, 1'b1, 22'h000000, 1'b0, 3'd0, 22'h000000, 4'd0);
        tbl[6] = mk(1'b0, 1'b1, 1'b1, 22'h010180, 1'b1, 3'd1, 22'h010180, 4'd1);
        tbl[7] = mk(1'b0, 1'b1, 1'b1, 22'h000000, 1'b1, 3'd1, 22'h000000, 4'd2);
        tbl[8] = mk(1'b0, 1'b1, 1'b1, 22'h000000, 1'b0, 3'd0, 22'h000000, 4'd0);

        sup_seen = 0;
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].rdy, tbl[i].y);
            check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].exp_level));
            if (tbl[i].exp_valid) begin
                check($sformatf("tbl%0d_word", i), 32'(out_word), 32'(tbl[i].exp_word));
                check($sformatf("tbl%0d_ts", i), 32'(out_ts), 32'(tbl[i].exp_ts));
            end
            if (i >= 5 && out_valid && out_word == 22'h010180) sup_seen = 1;
        end
        check("pulse_not_suppressed", 32'(sup_seen), 32'd1);

        // Overflow: six changes into a stalled FIFO, then push and pop while full.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(i));
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_cnt), 32'd2);
        check("ovf_head", 32'(out_word), 32'd1);
        step(1'b0, 1'b1, 1'b1, 22'd7);
        check("full_pp_level", 32'(level), 32'd4);
        check("full_pp_drops", 32'(drop_cnt), 32'd2);
        exp_heads = '{22'd2, 22'd3, 22'd4, 22'd7};
        exp_tss   = '{4'd1, 4'd2, 4'd3, 4'd6};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_word", i), 32'(out_word), 32'(exp_heads[i]));
            check($sformatf("drain%0d_ts", i), 32'(out_ts), 32'(exp_tss[i]));
            step(1'b0, 1'b0, 1'b1, 22'd7);
        end
        check("drain_empty", 32'(out_valid), 32'd0);

        // Drop counter saturation: 12 changes while stalled give 8 drops, capped at 7.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(i));
        check("drop_sat", 32'(drop_cnt), 32'd7);

        // Timestamp wrap over 20 changes, then a disabled window.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b1, WIDTH'(i + 1));
            check($sformatf("wrap%0d_ts", i), 32'(out_ts), 32'(i % 16));
        end
        step(1'b0, 1'b0, 1'b1, 22'd3);
        step(1'b0, 1'b0, 1'b1, 22'd11);
        step(1'b0, 1'b0, 1'b1, 22'd20);
        check("dis_no_entry", 32'(out_valid), 32'd0);
        step(1'b0, 1'b1, 1'b1, 22'd21);
        check("dis_ts_frozen", 32'(out_ts), 32'd4);

        // Reset mid-operation with entries stored, overflow set and a change pending.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(i));
        step(1'b0, 1'b0, 1'b1, 22'd5);
        check("mid_pre_level", 32'(level), 32'd3);
        step(1'b1, 1'b1, 1'b1, 22'd99);
        check("mid_level", 32'(level), 32'd0);
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_overflow", 32'(overflow), 32'd0);
        check("mid_drops", 32'(drop_cnt), 32'd0);
        step(1'b0, 1'b1, 1'b0, 22'd99);
        check("post_rst_level", 32'(level), 32'd1);
        check("post_rst_ts", 32'(out_ts), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [WIDTH-1:0] pool[4];
            pool = '{22'h000000, 22'h000482, 22'h010180, 22'h3fffff};
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 5), pool[$urandom_range(0, 3)]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
